// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST controller.
package mbist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN,
    ST_DONE
  } mbist_state_t;

  // Backgrounds are single bits replicated across the data word.
  localparam logic D0 = 1'b0;
  localparam logic D1 = 1'b1;

  localparam logic PH_RD = 1'b0;
  localparam logic PH_WR = 1'b1;

  typedef struct packed {
    logic down;
    logic rd_bg;
    logic wr_bg;
    logic has_rd;
    logic has_wr;
  } march_elem_t;

  localparam int unsigned NUM_ELEM = 6;

  localparam march_elem_t MARCH_TBL [NUM_ELEM] = '{
    '{down: 1'b0, rd_bg: D0, wr_bg: D0, has_rd: 1'b0, has_wr: 1'b1},  // M0 up(w0)
    '{down: 1'b0, rd_bg: D0, wr_bg: D1, has_rd: 1'b1, has_wr: 1'b1},  // M1 up(r0,w1)
    '{down: 1'b0, rd_bg: D1, wr_bg: D0, has_rd: 1'b1, has_wr: 1'b1},  // M2 up(r1,w0)
    '{down: 1'b1, rd_bg: D0, wr_bg: D1, has_rd: 1'b1, has_wr: 1'b1},  // M3 down(r0,w1)
    '{down: 1'b1, rd_bg: D1, wr_bg: D0, has_rd: 1'b1, has_wr: 1'b1},  // M4 down(r1,w0)
    '{down: 1'b0, rd_bg: D0, wr_bg: D0, has_rd: 1'b1, has_wr: 1'b0}   // M5 up(r0)
  };

  // Non-march states map to an all-zero descriptor: no access, ascending.
  function automatic march_elem_t elem_of(mbist_state_t s);
    case (s)
      ST_M0:   elem_of = MARCH_TBL[0];
      ST_M1:   elem_of = MARCH_TBL[1];
      ST_M2:   elem_of = MARCH_TBL[2];
      ST_M3:   elem_of = MARCH_TBL[3];
      ST_M4:   elem_of = MARCH_TBL[4];
      ST_M5:   elem_of = MARCH_TBL[5];
      default: elem_of = '0;
    endcase
  endfunction

  function automatic mbist_state_t next_elem_state(mbist_state_t s);
    case (s)
      ST_M0:   next_elem_state = ST_M1;
      ST_M1:   next_elem_state = ST_M2;
      ST_M2:   next_elem_state = ST_M3;
      ST_M3:   next_elem_state = ST_M4;
      ST_M4:   next_elem_state = ST_M5;
      ST_M5:   next_elem_state = ST_DRAIN;
      default: next_elem_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter with a terminal-count flag for one march element.
module mbist_addr_gen
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              tc_c_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  // Terminal address depends on the direction of the element currently running.
  assign tc_c_o = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a single-port SRAM with one-cycle read latency.
// Define MBIST_STOP_ON_FAIL_EN to end the run on the first mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  output logic              we,
  input  logic [DATA_W-1:0] ramout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        err_cnt
);

  localparam int unsigned ERR_W = 8;

  mbist_state_t state_q, state_d;
  logic phase_q, phase_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic we_q, we_d;
  logic [DATA_W-1:0] ramin_q, ramin_d;

  // Attributes of the access presented this cycle, registered with it.
  logic rd_q, rd_d;
  logic rd_bg_q, rd_bg_d;
  logic last_q, last_d;
  logic down_q, down_d;

  logic              cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;

  logic              ag_load;
  logic [ADDR_W-1:0] ag_load_val;
  logic              ag_step;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_tc;

  logic        mismatch;
  march_elem_t nxt_elem;

  mbist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ag_load),
    .load_val_i (ag_load_val),
    .step_i     (ag_step),
    .down_i     (down_q),
    .addr_o     (ag_addr),
    .tc_c_o     (ag_tc)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    err_d       = err_q;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_step     = 1'b0;
    cmp_vld_d   = rd_q;
    cmp_addr_d  = ag_addr;
    cmp_exp_d   = {DATA_W{rd_bg_q}};

    // Check the read issued last cycle against the data now on ramout.
    mismatch = cmp_vld_q && (ramout != cmp_exp_q);
    if (mismatch) begin
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_data_d = ramout;
      end
      if (err_q != '1) begin
        err_d = err_q + ERR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_M0;
          phase_d     = PH_RD;
          ag_load     = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          err_d       = '0;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        if (last_q) begin
          phase_d = PH_RD;
          if (ag_tc) begin
            state_d = next_elem_state(state_q);
            ag_load = 1'b1;
          end else begin
            ag_step = 1'b1;
          end
        end else begin
          phase_d = PH_WR;
        end
      end
    endcase

`ifdef MBIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_d   = ST_DONE;
      phase_d   = PH_RD;
      done_d    = 1'b1;
      ag_load   = 1'b1;
      ag_step   = 1'b0;
      cmp_vld_d = 1'b0;
    end
`endif

    // Decode the access for the next cycle from the state being entered.
    nxt_elem    = elem_of(state_d);
    ag_load_val = {ADDR_W{nxt_elem.down}};
    rd_d        = nxt_elem.has_rd && (!nxt_elem.has_wr || (phase_d == PH_RD));
    we_d        = nxt_elem.has_wr && (!nxt_elem.has_rd || (phase_d == PH_WR));
    last_d      = !(nxt_elem.has_rd && nxt_elem.has_wr) || (phase_d == PH_WR);
    ramin_d     = {DATA_W{we_d & nxt_elem.wr_bg}};
    rd_bg_d     = nxt_elem.rd_bg;
    down_d      = nxt_elem.down;
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_RD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_q       <= '0;
      we_q        <= 1'b0;
      ramin_q     <= '0;
      rd_q        <= 1'b0;
      rd_bg_q     <= 1'b0;
      last_q      <= 1'b0;
      down_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_q       <= err_d;
      we_q        <= we_d;
      ramin_q     <= ramin_d;
      rd_q        <= rd_d;
      rd_bg_q     <= rd_bg_d;
      last_q      <= last_d;
      down_q      <= down_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
    end
  end

  assign ramaddr   = ag_addr;
  assign ramin     = ramin_q;
  assign we        = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl: SRAM model with injectable faults,
// cycle-indexed March C- reference model, and directed scenarios.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] ramaddr;
  logic [7:0] ramin;
  logic       we;
  logic [7:0] ramout;
  logic       busy;
  logic       done;
  logic       fail;
  logic [7:0] fail_addr;
  logic [7:0] fail_data;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mbist_march_ctrl #(
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ramaddr   (ramaddr),
    .ramin     (ramin),
    .we        (we),
    .ramout    (ramout),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // SRAM: 0 = good, 1 = bit 3 stuck-at-0 at 0x17, 2 = writes to 0x40 also hit 0x41.
  int fault_mode = 0;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (we) begin
      mem[ramaddr] <= ramin;
      if (fault_mode == 2 && ramaddr == 8'h40) mem[8'h41] <= ramin;
    end
    if (fault_mode == 1 && ramaddr == 8'h17) ramout <= mem[ramaddr] & 8'hF7;
    else                                     ramout <= mem[ramaddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bus activity for run cycle k (1 = first cycle after start is accepted).
  function automatic void model_ops(input int k, output logic e_busy, output logic e_done,
                                    output logic e_we, output logic e_rd,
                                    output logic [7:0] e_addr, output logic [7:0] e_din,
                                    output logic [7:0] e_exp);
    int j, e, i;
    logic [7:0] rdv;
    e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0; e_rd = 1'b0;
    e_addr = 8'h00; e_din = 8'h00; e_exp = 8'h00;
    if (k >= 2562) begin
      e_done = 1'b1;
    end else if (k >= 1) begin
      e_busy = 1'b1;
      if (k <= 256) begin
        e_we   = 1'b1;
        e_addr = 8'(k - 1);
      end else if (k <= 2304) begin
        j   = k - 257;
        e   = j / 512;
        i   = (j % 512) / 2;
        rdv = (e % 2 == 0) ? 8'h00 : 8'hFF;
        e_addr = (e < 2) ? 8'(i) : 8'(255 - i);
        if (j % 2 == 0) begin
          e_rd  = 1'b1;
          e_exp = rdv;
        end else begin
          e_we  = 1'b1;
          e_din = ~rdv;
        end
      end else if (k <= 2560) begin
        e_rd   = 1'b1;
        e_addr = 8'(k - 2305);
      end
    end
  endfunction

  int         m_k = 0;
  logic       m_fail = 1'b0;
  logic [7:0] m_faddr = 8'h00;
  logic [7:0] m_fdata = 8'h00;
  int         m_err = 0;
  logic       p_vld = 1'b0;
  logic [7:0] p_addr = 8'h00;
  logic [7:0] p_exp = 8'h00;
  bit         stop_on_fail;

  initial begin
`ifdef MBIST_STOP_ON_FAIL_EN
    stop_on_fail = 1'b1;
`else
    stop_on_fail = 1'b0;
`endif
  end

  // Every cycle: compare all outputs to the model, then advance the model one cycle.
  always @(negedge clk) begin
    logic e_busy, e_done, e_we, e_rd, mm, running;
    logic [7:0] e_addr, e_din, e_exp;
    if (!rst_n) begin
      m_k = 0; m_fail = 1'b0; m_faddr = 8'h00; m_fdata = 8'h00; m_err = 0; p_vld = 1'b0;
    end
    model_ops(m_k, e_busy, e_done, e_we, e_rd, e_addr, e_din, e_exp);
    check("cycle_outputs",
          64'({busy, done, we, ramaddr, ramin, fail, fail_addr, fail_data, err_cnt}),
          64'({e_busy, e_done, e_we, e_addr, e_din, m_fail, m_faddr, m_fdata, 8'(m_err)}));
    if (rst_n) begin
      running = (m_k >= 1) && (m_k <= 2561);
      mm = p_vld && (ramout !== p_exp);
      if (mm) begin
        if (!m_fail) begin
          m_fail = 1'b1; m_faddr = p_addr; m_fdata = ramout;
        end
        if (m_err < 255) m_err++;
      end
      p_vld = running && e_rd; p_addr = e_addr; p_exp = e_exp;
      if (running) begin
        if (stop_on_fail && mm) begin
          m_k = 2562; p_vld = 1'b0;
        end else begin
          m_k++;
        end
      end else if (start) begin
        m_k = 1; m_fail = 1'b0; m_faddr = 8'h00; m_fdata = 8'h00; m_err = 0; p_vld = 1'b0;
      end
    end
  end

  // Raise start, pass edge 0 and check the accept cleared the result flags.
  task automatic launch(input bit hold);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("accept_clears", 64'({busy, done, fail, err_cnt}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
  endtask

  // Returns the cycle number in which done is first seen (cycle 1 follows edge 0).
  task automatic wait_done(input int pulse_at, output int cyc);
    int n = 0;
    while (!done && n < 4000) begin
      if (pulse_at > 0 && n == pulse_at)     start = 1'b0;
      if (pulse_at > 0 && n == pulse_at + 1) start = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got done=%0b after %0d cycles, required done=1", done, n);
    end
    cyc = n + 1;
  endtask

  int c;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    #1;
    check("reset_values", 64'({busy, done, we, ramaddr, ramin, fail, fail_addr, fail_data, err_cnt}), 64'h0);
    #20 rst_n = 1'b1;

    // Fault-free run.
    fault_mode = 0;
    launch(1'b0);
    wait_done(0, c);
    check("clean_done_cycle", 64'(c), 64'd2562);
    check("clean_result", 64'({busy, fail, err_cnt}), 64'({1'b0, 1'b0, 8'h00}));

    // Stuck-at-0 on bit 3 at 0x17, first seen by the M2 r1 read.
    fault_mode = 1;
    launch(1'b0);
    wait_done(0, c);
    check("sa0_fail", 64'(fail), 64'd1);
    check("sa0_fail_addr", 64'(fail_addr), 64'h17);
    check("sa0_fail_data", 64'(fail_data), 64'hF7);
`ifdef MBIST_STOP_ON_FAIL_EN
    check("sa0_done_cycle", 64'(c), 64'd817);
    check("sa0_err_cnt", 64'(err_cnt), 64'd1);
`else
    check("sa0_done_cycle", 64'(c), 64'd2562);
    check("sa0_err_cnt", 64'(err_cnt), 64'd2);
`endif

    // Address-decoder fault 0x40 -> 0x41, first seen by the M1 r0 read of 0x41.
    fault_mode = 2;
    launch(1'b0);
    wait_done(0, c);
    check("adf_fail_addr", 64'(fail_addr), 64'h41);
    check("adf_fail_data", 64'(fail_data), 64'hFF);
`ifdef MBIST_STOP_ON_FAIL_EN
    check("adf_done_cycle", 64'(c), 64'd389);
    check("adf_err_cnt", 64'(err_cnt), 64'd1);
`else
    check("adf_done_cycle", 64'(c), 64'd2562);
    check("adf_err_cnt", 64'(err_cnt), 64'd2);
`endif
    check("adf_idle_bus", 64'({busy, we, ramaddr, ramin}), 64'h0);

    // Asynchronous reset in cycle 1000, then a full fresh run.
    fault_mode = 0;
    launch(1'b0);
    repeat (999) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset", 64'({busy, done, we, ramaddr, ramin, fail, fail_addr, fail_data, err_cnt}), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    launch(1'b0);
    wait_done(0, c);
    check("after_reset_done_cycle", 64'(c), 64'd2562);

    // Start held high with a re-pulse mid-run: no restart until DONE.
    launch(1'b1);
    wait_done(499, c);
    check("held_start_done_cycle", 64'(c), 64'd2562);
    @(posedge clk); #1;
    check("restart_from_done", 64'({busy, done, fail, err_cnt}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
    start = 1'b0;
    wait_done(0, c);
    check("rerun_done_cycle", 64'(c), 64'd2562);
    check("rerun_result", 64'({fail, err_cnt}), 64'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- memory BIST controller that drives the 256x8 `bist_sram` array and checks its read data. It sits directly upstream of the SRAM, owning `ramaddr`/`ramin`/`we` during test and consuming `ramout`. It reports pass/fail, the first failing address and data, and a mismatch count to the chip-level test logic.

## Interface
Parameters:
- ADDR_W, 8, SRAM address width; the array depth is 2**ADDR_W.
- DATA_W, 8, SRAM data width.

Ports:
- clk  in  1  single clock, shared with the SRAM.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled in IDLE; launches a test run.
- ramaddr  out  ADDR_W  SRAM address, registered.
- ramin  out  DATA_W  SRAM write data, registered.
- we  out  1  SRAM write enable, registered.
- ramout  in  DATA_W  SRAM read data, valid one cycle after the read address.
- busy  out  1  high while a run is in progress.
- done  out  1  level; set at end of run, cleared by the next accepted start.
- fail  out  1  sticky; set on the first mismatch, cleared by the next accepted start.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_data  out  DATA_W  ramout value at the first mismatch.
- err_cnt  out  8  mismatch count; saturates at 255.

## Operation
- March C- sequence, with background D0 = all-0 and D1 = all-1:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- States: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
  - M1–M4 carry a phase bit, RD then WR, so each address takes 2 cycles.
  - M0 and M5 take 1 cycle per address.
- Address sequencing:
  - Ascending elements run addresses 0 to 255; descending elements run 255 to 0.
  - On the terminal address the state advances. There is no wrap within an element.
- Transitions:
  - IDLE → M0 on start.
  - Each element advances to the next element on its terminal address.
  - M5 → DRAIN after address 255.
  - DRAIN → DONE unconditionally.
  - DONE → M0 on start.
- Checking:
  - Every read cycle registers its address and expected data into a 1-deep compare pipe.
  - The compare happens in the following cycle against ramout.
  - On a mismatch: err_cnt increments, saturating at 255.
  - On the first mismatch only: fail is set, and fail_addr and fail_data are captured.
- start is ignored while busy=1. Accepting start clears done, fail, fail_addr, fail_data and err_cnt.
- While not busy: we=0, ramaddr=0, ramin=0.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Reset mid-run aborts immediately (asynchronous) and leaves SRAM contents undefined.
- Cycle numbering: start is sampled high on edge 0.
  - M0 runs cycles 1–256, with we=1 in cycle 1 at address 0.
  - M1: 257–768.
  - M2: 769–1280.
  - M3: 1281–1792.
  - M4: 1793–2304.
  - M5: 2305–2560.
  - DRAIN: 2561.
  - done=1 and busy=0 from cycle 2562.
- The compare of a read issued in cycle t uses ramout in cycle t+1, which is the WR phase or the next read.
- The DRAIN cycle exists only to compare the final M5 read.
- If a mismatch occurs in the same cycle the err_cnt is already 255, err_cnt stays at 255 and fail behaves normally.
- fail_addr and fail_data are written once per run and never overwritten.

## Configuration
- MBIST_STOP_ON_FAIL_EN defined:
  - On the first mismatch the FSM goes to DONE on the next edge: done=1, busy=0, we=0.
  - err_cnt=1 at that point.
- MBIST_STOP_ON_FAIL_EN undefined:
  - The run always completes the full 2561-cycle sequence.
  - fail, fail_addr and fail_data hold the first mismatch; err_cnt counts all mismatches.

## Structure
- Package mbist_pkg holds:
  - the state enum `mbist_state_t`;
  - the background constants D0 and D1;
  - the march element descriptor typedef: direction, read-expected value, write value, has-read, has-write;
  - the constant table for M0–M5.
- Sub-module mbist_addr_gen: up/down loadable address counter with a terminal-count flag, reused per element.

## Test plan
- Fault-free SRAM model, start pulsed at cycle 0 → done rises at cycle 2562, fail=0, err_cnt=0.
- Stuck-at-0 on bit 3 at address 0x17 → fail=1, fail_addr=0x17, fail_data=0xF7.
  - First detection is in M2 (r1).
  - Without the macro, err_cnt=2 at the end, from the M2 and M4 r1 reads.
- Address-decoder fault where writes to 0x40 also write 0x41 → fail_addr=0x41, fail_data=0xFF, detected in M1.
- Same fault as the previous scenario, with MBIST_STOP_ON_FAIL_EN defined → done one cycle after detection, err_cnt=1, no further we pulses.
- rst_n low at cycle 1000 → all outputs are 0 in the same cycle. A new start after release runs the full sequence to done at start+2562.
- start held high through the run and pulsed again at cycle 500 → no restart; done still at 2562. A start in DONE clears done, fail and err_cnt, and rerun begins.
